note_tone_generator: RTL and testbench
======================================

NOTE_TONE_GENERATOR -- requirements
Module: note_tone_generator

Interface
REQ-001 The module SHALL have parameter CLK_FREQ, default 50000000, meaning the i_clk frequency in Hz (legal range 4 to 2^30).
REQ-002 The module SHALL have parameter BEAT_FREQ, default 8, meaning the beat rate in Hz (legal range 1 to CLK_FREQ/4).
REQ-003 The module SHALL have port i_clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The module SHALL have port i_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The module SHALL have port i_freq, input, 24 bits: requested note frequency in Hz, unsigned; 0 means rest (silence).
REQ-006 The module SHALL have port o_pulse, output, 1 bit: square wave at the note frequency, driving the speaker.
REQ-007 The module SHALL have port o_beat_clk, output, 1 bit: square wave at BEAT_FREQ.
REQ-008 The module SHALL have port o_beat, output, 1 bit: one-cycle strobe asserted in the cycle o_beat_clk rises.

Function
REQ-009 Each channel (note and beat) SHALL use a 32-bit phase accumulator (acc) and a toggle flop; no divider circuit is permitted.
REQ-010 Each cycle, each channel SHALL compute sum = acc + 2*F, where F is the effective frequency of that channel.
REQ-011 If sum >= CLK_FREQ, the channel SHALL set acc to sum - CLK_FREQ and invert its output; otherwise it SHALL set acc to sum and hold its output.
REQ-012 The long-term output frequency SHALL therefore equal F exactly, with edge jitter of at most one i_clk period.
REQ-013 For the note channel, F SHALL be i_freq clamped to MAX_NOTE = CLK_FREQ/4 (integer division); values above MAX_NOTE SHALL behave exactly as MAX_NOTE.
REQ-014 When i_freq = 0, the note channel SHALL clear acc and force o_pulse low on the next rising edge, and SHALL hold both at 0 while i_freq stays 0.
REQ-015 A change of i_freq between non-zero values SHALL NOT clear acc or o_pulse; the new increment SHALL apply from the next edge (glitch-free, phase-continuous).
REQ-016 A change of i_freq from 0 to non-zero SHALL start the note channel from acc = 0 with o_pulse low, so the first toggle occurs ceil(CLK_FREQ/(2F)) edges later.
REQ-017 For the beat channel, F SHALL be the constant BEAT_FREQ; the beat channel SHALL run continuously and be unaffected by i_freq.
REQ-018 o_beat SHALL be 1 for exactly one cycle: the cycle following the edge on which o_beat_clk changes 0->1 (registered, aligned with o_beat_clk high).
REQ-019 o_beat SHALL be 0 on the 1->0 transition of o_beat_clk.
REQ-020 All outputs SHALL be driven directly from registers, with no combinational path from i_freq to any output.
REQ-021 The accumulator add and compare SHALL be carried out at 32 bits, so no overflow occurs for legal parameters.

Reset
REQ-022 While i_rst_n = 0, both accumulators SHALL be 0 and o_pulse, o_beat_clk and o_beat SHALL be 0, asynchronously.
REQ-023 After i_rst_n deasserts, operation SHALL begin on the first rising edge of i_clk.
REQ-024 Reset asserted mid-period SHALL abandon the current phase with no partial pulse, and no state SHALL survive it.

Verification
REQ-025 With CLK_FREQ=100, i_freq=10 held from reset release: o_pulse SHALL first rise on the 5th edge and then toggle every 5 edges (period 10 cycles).
REQ-026 With CLK_FREQ=100, i_freq=25: o_pulse SHALL toggle every 2 edges; with i_freq=1000 it SHALL behave identically to 25 (clamp).
REQ-027 With CLK_FREQ=100, i_freq=15: the intervals between toggles SHALL alternate 4,3,3,... cycles, giving 30 toggles per 100 cycles over any 100-cycle window (±1).
REQ-028 With CLK_FREQ=100, BEAT_FREQ=5: o_beat_clk SHALL toggle every 10 edges, and o_beat SHALL pulse exactly once per 20 cycles, coincident with the first cycle o_beat_clk is high.
REQ-029 With i_freq switching 10 -> 0 mid-high-phase: o_pulse SHALL be 0 after the next edge and SHALL stay 0; with i_freq switching back to 10, the first rise SHALL come 5 edges later.
REQ-030 With i_rst_n pulsed low asynchronously mid-operation (between clock edges): all outputs SHALL go 0 immediately, and after release the REQ-025 timing SHALL repeat exactly.

Source files
------------

// File: rtl/note_tone_generator.sv
// Note/beat square-wave generator built from two 32-bit phase accumulators.
// The note rate follows i_freq (clamped to CLK_FREQ/4) and the beat rate is fixed at BEAT_FREQ.
module note_tone_generator #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BEAT_FREQ = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [23:0] i_freq,
  output logic        o_pulse,
  output logic        o_beat_clk,
  output logic        o_beat
);

  localparam logic [31:0] CLK_F    = 32'(CLK_FREQ);
  localparam logic [31:0] MAX_NOTE = 32'(CLK_FREQ / 4);
  localparam logic [31:0] BEAT_INC = 32'(2 * BEAT_FREQ);

  // Channel 0 is the note and channel 1 is the beat.
  logic [31:0] inc   [2];
  logic [1:0]  clear;
  logic [1:0]  chan_out;
  logic [1:0]  chan_rise;
  logic [31:0] note_f;
  logic        beat_reg;

  always_comb begin
    note_f = {8'd0, i_freq};
    if (note_f > MAX_NOTE) begin
      note_f = MAX_NOTE;
    end
    inc[0]   = {note_f[30:0], 1'b0};
    inc[1]   = BEAT_INC;
    clear[0] = (i_freq == 24'd0);
    clear[1] = 1'b0;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic [31:0] acc_reg;
      logic [31:0] acc_next;
      logic        out_reg;
      logic        out_next;
      logic [31:0] sum;
      logic        wrap;

      always_comb begin
        sum      = acc_reg + inc[gi];
        wrap     = (sum >= CLK_F);
        acc_next = sum;
        out_next = out_reg;
        if (clear[gi]) begin
          acc_next = 32'd0;
          out_next = 1'b0;
        end else if (wrap) begin
          acc_next = sum - CLK_F;
          out_next = ~out_reg;
        end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          acc_reg <= 32'd0;
          out_reg <= 1'b0;
        end else begin
          acc_reg <= acc_next;
          out_reg <= out_next;
        end
      end

      assign chan_out[gi]  = out_reg;
      // The output is about to go from 0 to 1 on this edge.
      assign chan_rise[gi] = out_next & ~out_reg;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat_reg <= 1'b0;
    end else begin
      beat_reg <= chan_rise[1];
    end
  end

  assign o_pulse    = chan_out[0];
  assign o_beat_clk = chan_out[1];
  assign o_beat     = beat_reg;

endmodule

// File: tb/tb_note_tone_generator.sv
// Directed bench for note_tone_generator at CLK_FREQ=100, BEAT_FREQ=5.
// Expected outputs are queued per edge from closed-form edge counts and then checked after that edge.
module tb_note_tone_generator;

  localparam int CLK_FREQ  = 100;
  localparam int BEAT_FREQ = 5;

  logic        clk;
  logic        rst_n;
  logic [23:0] freq;
  logic        pulse;
  logic        beat_clk;
  logic        beat;

  note_tone_generator #(.CLK_FREQ(CLK_FREQ), .BEAT_FREQ(BEAT_FREQ)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_freq     (freq),
    .o_pulse    (pulse),
    .o_beat_clk (beat_clk),
    .o_beat     (beat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic  pulse;
    logic  bclk;
    logic  beat;
    string tag;
  } exp_t;

  exp_t    sb[$];
  int      compared   = 0;
  int      mismatched = 0;
  longint  note_n     = 0;   // edges since the note phase last restarted from zero
  longint  beat_n     = 0;   // edges since reset release

  function automatic longint eff_f(input logic [23:0] f);
    return (f > 24'(CLK_FREQ / 4)) ? longint'(CLK_FREQ / 4) : longint'(f);
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Queue the expected state after the next edge, run that edge, then check the outputs.
  task automatic step(input string tag);
    exp_t   e;
    longint f;
    longint bp;
    longint bc;
    f = eff_f(freq);
    if (freq == 24'd0) begin
      note_n  = 0;
      e.pulse = 1'b0;
    end else begin
      note_n++;
      e.pulse = logic'(((note_n * 2 * f) / CLK_FREQ) % 2);
    end
    beat_n++;
    bp     = ((beat_n - 1) * 2 * BEAT_FREQ) / CLK_FREQ;
    bc     = (beat_n * 2 * BEAT_FREQ) / CLK_FREQ;
    e.bclk = logic'(bc % 2);
    e.beat = logic'((bc != bp) && (bc % 2 == 1));
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_bit({e.tag, "_pulse"}, pulse, e.pulse);
    check_bit({e.tag, "_beat_clk"}, beat_clk, e.bclk);
    check_bit({e.tag, "_beat"}, beat, e.beat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_bit({tag, "_pulse"}, pulse, 1'b0);
    check_bit({tag, "_beat_clk"}, beat_clk, 1'b0);
    check_bit({tag, "_beat"}, beat, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    freq  = 24'd10;
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    #2;
    check_reset_outputs("reset_edge");
    rst_n = 1'b1;

    // 10 Hz from release: first rise on edge 5, then a toggle every 5 edges.
    for (int i = 0; i < 25; i++) step("f10");
    $display("txn f10 done: pulse=%b beat_clk=%b", pulse, beat_clk);

    // 10 -> 0 while o_pulse is high, then back to 10.
    while (pulse !== 1'b1 && note_n < 40) step("f10_seek_high");
    check_bit("f10_is_high_before_rest", pulse, 1'b1);
    freq = 24'd0;
    for (int i = 0; i < 12; i++) step("rest");
    freq = 24'd10;
    for (int i = 0; i < 12; i++) step("f10_restart");
    $display("txn rest/restart done: note_n=%0d", note_n);

    // Move to 25 by way of a rest so the phase starts from zero again.
    freq = 24'd0;
    step("rest2");
    freq = 24'd25;
    for (int i = 0; i < 10; i++) step("f25");
    freq = 24'd1000;
    for (int i = 0; i < 10; i++) step("f1000_clamp");
    $display("txn clamp done: pulse=%b", pulse);

    // 15 Hz: toggle intervals 4,3,3 repeating, 30 toggles per 100 edges.
    freq = 24'd0;
    step("rest3");
    freq = 24'd15;
    for (int i = 0; i < 40; i++) step("f15");
    $display("txn f15 done: pulse=%b", pulse);

    // Assert reset asynchronously mid-period; the timing from release must repeat.
    freq = 24'd10;
    step("pre_rst");
    step("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #2;
    check_reset_outputs("async_rst_edge");
    rst_n  = 1'b1;
    note_n = 0;
    beat_n = 0;
    for (int i = 0; i < 45; i++) step("f10_after_rst");
    $display("txn post-reset done: pulse=%b beat_clk=%b", pulse, beat_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
